cpu_ctrl_sequencer: RTL

//  Parametrised successor to the single-cycle opcode decoder. Accepts instruction words over a

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/op_decode_rom.sv | 75 +++++++
 rtl/cpu_ctrl_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, FSM states and control-word layout for the
// control sequencer and its opcode decode ROM.
package cpu_ctrl_pkg;

  localparam int OP_SET    = 0;
  localparam int OP_COPY   = 1;
  localparam int OP_ADD    = 2;
  localparam int OP_INC    = 3;
  localparam int OP_SUB    = 4;
  localparam int OP_DEC    = 5;
  localparam int OP_AND    = 6;
  localparam int OP_OR     = 7;
  localparam int OP_XOR    = 8;
  localparam int OP_SKIPIF = 9;
  localparam int OP_HALT   = 10;

  localparam int CSEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SKIP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  typedef struct packed {
    logic [CSEL_W-1:0] aluSel;
    logic              carryIn;
    logic              bSel;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic ctrl_t mkCtrl(
    input logic [CSEL_W-1:0] sel,
    input logic              ci,
    input logic              bs
  );
    ctrl_t c;
    c.aluSel  = sel;
    c.carryIn = ci;
    c.bSel    = bs;
    return c;
  endfunction

endpackage

// File: rtl/op_decode_rom.sv
// Combinational opcode decode: control word plus class flags.
// Ports: opcode in; ctrlWord, isAlu, isSkip, isHalt, isIllegal out.
module op_decode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0]   opcode,
  output logic [CTRL_W-1:0] ctrlWord,
  output logic              isAlu,
  output logic              isSkip,
  output logic              isHalt,
  output logic              isIllegal
);

  ctrl_t c;

  always_comb begin
    c         = '0;
    isAlu     = 1'b0;
    isSkip    = 1'b0;
    isHalt    = 1'b0;
    isIllegal = 1'b0;
    unique case (1'b1)
      (opcode == OP_W'(OP_SET)): begin
        c     = mkCtrl(3'b111, 1'b0, 1'b0);
        isAlu = 1'b1;
      end
      (opcode == OP_W'(OP_COPY)): begin
        c     = mkCtrl(3'b000, 1'b0, 1'b0);
        isAlu = 1'b1;
      end
      (opcode == OP_W'(OP_ADD)): begin
        c     = mkCtrl(3'b001, 1'b0, 1'b1);
        isAlu = 1'b1;
      end
      (opcode == OP_W'(OP_INC)): begin
        c     = mkCtrl(3'b000, 1'b1, 1'b0);
        isAlu = 1'b1;
      end
      (opcode == OP_W'(OP_SUB)): begin
        c     = mkCtrl(3'b010, 1'b1, 1'b1);
        isAlu = 1'b1;
      end
      (opcode == OP_W'(OP_DEC)): begin
        c     = mkCtrl(3'b011, 1'b0, 1'b0);
        isAlu = 1'b1;
      end
      (opcode == OP_W'(OP_AND)): begin
        c     = mkCtrl(3'b100, 1'b0, 1'b1);
        isAlu = 1'b1;
      end
      (opcode == OP_W'(OP_OR)): begin
        c     = mkCtrl(3'b100, 1'b1, 1'b1);
        isAlu = 1'b1;
      end
      (opcode == OP_W'(OP_XOR)): begin
        c     = mkCtrl(3'b101, 1'b0, 1'b1);
        isAlu = 1'b1;
      end
      (opcode == OP_W'(OP_SKIPIF)): begin
        isSkip = 1'b1;
      end
      (opcode == OP_W'(OP_HALT)): begin
        isHalt = 1'b1;
      end
      default: begin
        isIllegal = 1'b1;
      end
    endcase
  end

  assign ctrlWord = c;

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Instruction control sequencer: handshake accept, decode, hold
// the registered control word for EXEC_CYCLES, skip/halt/illegal.
// Ports: clk, reset; instr/instr_valid/instr_ready handshake;
// cond_flag, resume; ALU/regfile controls and status flags out.
module cpu_ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int RA_W        = 2,
  parameter int SEL_W       = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_W+2*RA_W-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic                   cond_flag,
  input  logic                   resume,
  output logic [SEL_W-1:0]       alu_sel,
  output logic                   carry_in,
  output logic                   b_sel,
  output logic [RA_W-1:0]        dst_addr,
  output logic [RA_W-1:0]        src_addr,
  output logic                   ctrl_valid,
  output logic                   reg_we,
  output logic                   halted,
  output logic                   skip_active,
  output logic                   illegal_op
);

  localparam int IW    = OP_W + 2*RA_W;
  localparam int CNT_W = $clog2(EXEC_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(EXEC_CYCLES - 1);

  state_t            state;
  state_t            stateNext;
  logic [CNT_W-1:0]  cnt;
  logic              lastCycle;
  logic              accept;
  logic              inIdle;

  logic [OP_W-1:0]   opcode;
  logic [RA_W-1:0]   dstField;
  logic [RA_W-1:0]   srcField;

  ctrl_t             decCtrl;
  logic              isAlu;
  logic              isSkip;
  logic              isHalt;
  logic              isIllegal;

  ctrl_t             ctrlQ;
  logic [RA_W-1:0]   dstQ;
  logic [RA_W-1:0]   srcQ;
  logic              illQ;

  assign opcode   = instr[IW-1 -: OP_W];
  assign dstField = instr[2*RA_W-1 -: RA_W];
  assign srcField = instr[RA_W-1:0];

  op_decode_rom #(
    .OP_W(OP_W)
  ) uRom (
    .opcode   (opcode),
    .ctrlWord (decCtrl),
    .isAlu    (isAlu),
    .isSkip   (isSkip),
    .isHalt   (isHalt),
    .isIllegal(isIllegal)
  );

  // Gated by reset so the handshake stays closed while held in reset.
  assign instr_ready = !reset &&
    (state == ST_IDLE || state == ST_SKIP);

  assign accept    = instr_valid && instr_ready;
  assign inIdle    = (state == ST_IDLE);
  assign lastCycle = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (isAlu)
            stateNext = ST_EXEC;
          else if (isSkip && cond_flag)
            stateNext = ST_SKIP;
          else if (isHalt)
            stateNext = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (lastCycle) stateNext = ST_IDLE;
      end
      // Whatever is accepted here is dropped, so skips never chain.
      ST_SKIP: begin
        if (accept) stateNext = ST_IDLE;
      end
      ST_HALT: begin
        if (resume) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Held at zero outside EXEC so every EXEC entry starts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state != ST_EXEC)
      cnt <= '0;
    else if (!lastCycle)
      cnt <= cnt + CNT_W'(1);
  end

  // Control word only reloads on an executed ALU op;
  // it keeps its last value otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrlQ <= '0;
      dstQ  <= '0;
      srcQ  <= '0;
    end else if (inIdle && accept && isAlu) begin
      ctrlQ <= decCtrl;
      dstQ  <= dstField;
      srcQ  <= srcField;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illQ <= 1'b0;
    else       illQ <= inIdle && accept && isIllegal;
  end

  assign alu_sel     = SEL_W'(ctrlQ.aluSel);
  assign carry_in    = ctrlQ.carryIn;
  assign b_sel       = ctrlQ.bSel;
  assign dst_addr    = dstQ;
  assign src_addr    = srcQ;
  assign ctrl_valid  = (state == ST_EXEC);
  assign reg_we      = (state == ST_EXEC) && lastCycle;
  assign halted      = (state == ST_HALT);
  assign skip_active = (state == ST_SKIP);
  assign illegal_op  = illQ;

endmodule
